// File: rtl/playfield_framebuffer_pkg.sv
// Shared definitions for the playfield window: bounds, colour width,
// colour constants, scan FSM states and pixel address helpers.
package playfield_framebuffer_pkg;

  localparam int X_MIN    = 120;
  localparam int X_MAX    = 199;
  localparam int Y_MAX    = 239;
  localparam int COLOUR_W = 3;
  localparam int WIDTH    = X_MAX - X_MIN + 1;
  localparam int ADDR_W   = 15;
  localparam int DEPTH    = WIDTH * (Y_MAX + 1);
  localparam int X_W      = 9;
  localparam int Y_W      = 8;

  localparam logic [COLOUR_W-1:0] WHITE = 3'b111;
  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;

  typedef enum logic [1:0] {
    SCAN_IDLE    = 2'd0,
    SCAN_FETCH   = 2'd1,
    SCAN_WAIT    = 2'd2,
    SCAN_PRESENT = 2'd3
  } scan_state_e;

  // True when (x, y) lies inside the stored window.
  function automatic logic in_window(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (x >= X_W'(X_MIN)) && (x <= X_W'(X_MAX)) && (y <= Y_W'(Y_MAX));
  endfunction

  // Linear RAM address of an in-window pixel; the 80-wide case avoids a multiplier.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] col;
    if (WIDTH == 80) begin
      row_base = (ADDR_W'(y) << 6) + (ADDR_W'(y) << 4);
    end else begin
      row_base = ADDR_W'(y) * ADDR_W'(WIDTH);
    end
    col = ADDR_W'(x) - ADDR_W'(X_MIN);
    return row_base + col;
  endfunction

endpackage

// File: rtl/playfield_framebuffer_if.sv
// Plot stream, clip status and scan-out handshake between the drawing
// engines / readback consumer (master) and the framebuffer (slave).
interface playfield_framebuffer_if;
  import playfield_framebuffer_pkg::*;

  logic [X_W-1:0]      wr_x;
  logic [Y_W-1:0]      wr_y;
  logic [COLOUR_W-1:0] wr_colour;
  logic                wr_plot;
  logic                clip_flag;
  logic                clip_clear;
  logic                scan_start;
  logic                scan_busy;
  logic                out_valid;
  logic                out_ready;
  logic [X_W-1:0]      out_x;
  logic [Y_W-1:0]      out_y;
  logic [COLOUR_W-1:0] out_colour;
  logic                scan_done;

  modport master (
    output wr_x, wr_y, wr_colour, wr_plot, clip_clear, scan_start, out_ready,
    input  clip_flag, scan_busy, out_valid, out_x, out_y, out_colour, scan_done
  );

  modport slave (
    input  wr_x, wr_y, wr_colour, wr_plot, clip_clear, scan_start, out_ready,
    output clip_flag, scan_busy, out_valid, out_x, out_y, out_colour, scan_done
  );

endinterface

// File: rtl/playfield_framebuffer_fb_ram_sdp.sv
// Simple dual-port pixel RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old data.
module fb_ram_sdp
  import playfield_framebuffer_pkg::*;
(
  input  logic                clock,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [COLOUR_W-1:0] wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [COLOUR_W-1:0] rd_data
);

  logic [COLOUR_W-1:0] mem_r [0:DEPTH-1];

  // Write port: store the plotted colour.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read port: registered, sees the array before this edge's write.
  always_ff @(posedge clock) begin
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/playfield_framebuffer.sv
// Playfield framebuffer: accepts the pixel plot stream into on-chip RAM,
// flags out-of-window plots, and scans the window out in raster order
// over a valid/ready handshake.
module playfield_framebuffer
  import playfield_framebuffer_pkg::*;
(
  input  logic                    clock,
  input  logic                    resetn,
  playfield_framebuffer_if.slave  bus
);

  logic                wr_en_s;
  logic                clip_hit_s;
  logic [ADDR_W-1:0]   wr_addr_s;
  logic [ADDR_W-1:0]   rd_addr_s;
  logic                rd_en_s;
  logic [COLOUR_W-1:0] rd_data_s;

  scan_state_e         state_r;
  logic [X_W-1:0]      sx_r;
  logic [Y_W-1:0]      sy_r;
  logic                clip_flag_r;
  logic                scan_busy_r;
  logic                scan_done_r;
  logic                out_valid_r;
  logic [X_W-1:0]      out_x_r;
  logic [Y_W-1:0]      out_y_r;
  logic [COLOUR_W-1:0] out_colour_r;

  // Split the plot strobe into an in-window write or a clip event.
  always_comb begin
    wr_en_s    = 1'b0;
    clip_hit_s = 1'b0;
    if (bus.wr_plot) begin
      if (in_window(bus.wr_x, bus.wr_y)) begin
        wr_en_s = 1'b1;
      end else begin
        clip_hit_s = 1'b1;
      end
    end else begin
      wr_en_s    = 1'b0;
      clip_hit_s = 1'b0;
    end
  end

  // RAM addresses for the plot port and the scan cursor.
  always_comb begin
    wr_addr_s = pixel_addr(bus.wr_x, bus.wr_y);
    rd_addr_s = pixel_addr(sx_r, sy_r);
    rd_en_s   = (state_r == SCAN_FETCH);
  end

  fb_ram_sdp u_ram (
    .clock   (clock),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (bus.wr_colour),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // Sticky clip flag; a new clip event beats a simultaneous clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clip_flag_r <= 1'b0;
    end else if (clip_hit_s) begin
      clip_flag_r <= 1'b1;
    end else if (bus.clip_clear) begin
      clip_flag_r <= 1'b0;
    end
  end

  // Scan FSM: fetch, wait one cycle for RAM data, present until accepted.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r      <= SCAN_IDLE;
      sx_r         <= 9'd0;
      sy_r         <= 8'd0;
      scan_busy_r  <= 1'b0;
      scan_done_r  <= 1'b0;
      out_valid_r  <= 1'b0;
      out_x_r      <= 9'd0;
      out_y_r      <= 8'd0;
      out_colour_r <= BLACK;
    end else begin
      scan_done_r <= 1'b0;
      case (state_r)
        SCAN_IDLE: begin
          if (bus.scan_start) begin
            sx_r        <= X_W'(X_MIN);
            sy_r        <= 8'd0;
            scan_busy_r <= 1'b1;
            state_r     <= SCAN_FETCH;
          end
        end
        SCAN_FETCH: begin
          state_r <= SCAN_WAIT;
        end
        SCAN_WAIT: begin
          out_colour_r <= rd_data_s;
          out_x_r      <= sx_r;
          out_y_r      <= sy_r;
          out_valid_r  <= 1'b1;
          state_r      <= SCAN_PRESENT;
        end
        SCAN_PRESENT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if ((sx_r == X_W'(X_MAX)) && (sy_r == Y_W'(Y_MAX))) begin
              scan_busy_r <= 1'b0;
              scan_done_r <= 1'b1;
              state_r     <= SCAN_IDLE;
            end else begin
              if (sx_r == X_W'(X_MAX)) begin
                sx_r <= X_W'(X_MIN);
                sy_r <= sy_r + 8'd1;
              end else begin
                sx_r <= sx_r + 9'd1;
              end
              state_r <= SCAN_FETCH;
            end
          end
        end
        default: begin
          state_r     <= SCAN_IDLE;
          scan_busy_r <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.clip_flag  = clip_flag_r;
  assign bus.scan_busy  = scan_busy_r;
  assign bus.scan_done  = scan_done_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_x      = out_x_r;
  assign bus.out_y      = out_y_r;
  assign bus.out_colour = out_colour_r;

endmodule

// File: tb/tb_playfield_framebuffer.sv
// Directed bench for playfield_framebuffer: plotting, clipping, scan-out
// handshake, asynchronous reset mid-scan and read/write collision.
module tb_playfield_framebuffer;

  logic clock;
  logic resetn;
  int   tests_run;
  int   tests_failed;
  int   done_cnt;

  logic [2:0] mdl   [0:19199];
  bit         known [0:19199];
  logic [2:0] cap   [0:19199];

  playfield_framebuffer_if bus();

  playfield_framebuffer dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic plot(input int x, input int y, input logic [2:0] c);
    bus.wr_x      = 9'(x);
    bus.wr_y      = 8'(y);
    bus.wr_colour = c;
    bus.wr_plot   = 1'b1;
    tick();
    bus.wr_plot   = 1'b0;
    if (x >= 120 && x <= 199 && y <= 239) begin
      mdl[y*80 + x - 120]   = c;
      known[y*80 + x - 120] = 1'b1;
    end
  endtask

  // Consume n pixels of an already started scan, checking raster order,
  // hold stability under back-pressure and colours of written pixels.
  task automatic scan_pixels(input string tag, input int n, input bit rnd, input int pulse_at);
    int ex, ey, cyc, idx, got;
    int order_err, col_err, hold_err;
    bit held;
    logic [8:0] hx;
    logic [7:0] hy;
    logic [2:0] hc;
    ex = 120; ey = 0; cyc = 0; got = 0;
    order_err = 0; col_err = 0; hold_err = 0; held = 1'b0;
    hx = 9'd0; hy = 8'd0; hc = 3'd0;
    while (got < n && cyc < n*8 + 20) begin
      bus.out_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.scan_start = (pulse_at >= 0 && got == pulse_at) ? 1'b1 : 1'b0;
      if (bus.out_valid) begin
        if (held && (bus.out_x !== hx || bus.out_y !== hy || bus.out_colour !== hc))
          hold_err++;
        if (bus.out_ready) begin
          if (bus.out_x !== 9'(ex) || bus.out_y !== 8'(ey)) order_err++;
          idx = ey*80 + ex - 120;
          cap[idx] = bus.out_colour;
          if (known[idx] && bus.out_colour !== mdl[idx]) col_err++;
          if (ex == 199) begin ex = 120; ey++; end
          else ex++;
          got++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hx = bus.out_x; hy = bus.out_y; hc = bus.out_colour;
        end
      end
      tick();
      cyc++;
      if (bus.scan_done) done_cnt++;
    end
    bus.scan_start = 1'b0;
    check({tag, "_count"}, got, n);
    check({tag, "_order"}, order_err, 0);
    check({tag, "_colour"}, col_err, 0);
    check({tag, "_hold"}, hold_err, 0);
  endtask

  initial begin
    int waits;
    tests_run = 0; tests_failed = 0; done_cnt = 0;
    for (int i = 0; i < 19200; i++) begin
      known[i] = 1'b0; mdl[i] = 3'd0; cap[i] = 3'd0;
    end
    bus.wr_x = 9'd0; bus.wr_y = 8'd0; bus.wr_colour = 3'd0; bus.wr_plot = 1'b0;
    bus.clip_clear = 1'b0; bus.scan_start = 1'b0; bus.out_ready = 1'b0;
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    // Reset state
    check("rst_out_valid",  bus.out_valid,  0);
    check("rst_scan_busy",  bus.scan_busy,  0);
    check("rst_scan_done",  bus.scan_done,  0);
    check("rst_clip_flag",  bus.clip_flag,  0);
    check("rst_out_x",      bus.out_x,      0);
    check("rst_out_y",      bus.out_y,      0);
    check("rst_out_colour", bus.out_colour, 0);

    // Fill rows 0..1 with a pattern, then the specific test pixels
    for (int y = 0; y < 2; y++)
      for (int x = 120; x < 200; x++)
        plot(x, y, 3'((x + y) & 7));
    plot(199, 4, 3'b001);
    plot(120, 6, 3'b001);
    plot(199, 239, 3'b010);
    plot(150, 100, 3'b101);
    plot(120, 0, 3'b111);
    check("clip_in_window", bus.clip_flag, 0);

    // Out-of-window plots are dropped and set the sticky flag
    plot(119, 5, 3'b110);
    check("clip_left", bus.clip_flag, 1);
    plot(200, 5, 3'b110);
    plot(130, 240, 3'b110);
    check("clip_sticky", bus.clip_flag, 1);
    bus.clip_clear = 1'b1; tick(); bus.clip_clear = 1'b0;
    check("clip_cleared", bus.clip_flag, 0);
    bus.clip_clear = 1'b1;
    plot(300, 0, 3'b110);
    bus.clip_clear = 1'b0;
    check("clip_set_wins", bus.clip_flag, 1);
    bus.clip_clear = 1'b1; tick(); bus.clip_clear = 1'b0;
    check("clip_cleared2", bus.clip_flag, 0);

    // Partial scan with random back-pressure: rows 0..6, includes row wraps
    done_cnt = 0;
    bus.scan_start = 1'b1; tick(); bus.scan_start = 1'b0;
    check("busy_after_start", bus.scan_busy, 1);
    scan_pixels("rnd", 500, 1'b1, -1);
    check("rnd_no_done", done_cnt, 0);
    check("clip_neighbour_a", cap[399], 3'b001);
    check("clip_neighbour_b", cap[480], 3'b001);

    // Asynchronous reset while a pixel is presented
    bus.out_ready = 1'b0;
    waits = 0;
    while (!bus.out_valid && waits < 10) begin tick(); waits++; end
    check("pre_reset_valid", bus.out_valid, 1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_valid", bus.out_valid, 0);
    check("async_rst_busy",  bus.scan_busy, 0);
    check("async_rst_done",  bus.scan_done, 0);
    tick();
    resetn = 1'b1;
    tick();

    // Full scan at full rate; a second start mid-scan must be ignored
    done_cnt = 0;
    bus.out_ready = 1'b1;
    bus.scan_start = 1'b1; tick(); bus.scan_start = 1'b0;
    check("lat_cycle0", bus.out_valid, 0);
    tick();
    check("lat_cycle1", bus.out_valid, 0);
    tick();
    check("lat_cycle2", bus.out_valid, 1);
    scan_pixels("full", 19200, 1'b0, 1000);
    repeat (3) begin
      tick();
      if (bus.scan_done) done_cnt++;
    end
    check("full_done_once",  done_cnt, 1);
    check("full_busy_clear", bus.scan_busy, 0);
    check("pix_first",  cap[0],     3'b111);
    check("pix_last",   cap[19199], 3'b010);
    check("pix_middle", cap[8030],  3'b101);

    // Collision: plot (120,0) in the cycle the scan fetches it
    bus.out_ready = 1'b0;
    bus.scan_start = 1'b1; tick(); bus.scan_start = 1'b0;
    bus.wr_x = 9'd120; bus.wr_y = 8'd0; bus.wr_colour = 3'b011; bus.wr_plot = 1'b1;
    tick();
    bus.wr_plot = 1'b0;
    mdl[0] = 3'b011;
    tick();
    check("coll_valid",      bus.out_valid,  1);
    check("coll_x",          bus.out_x,      120);
    check("coll_y",          bus.out_y,      0);
    check("coll_old_colour", bus.out_colour, 3'b111);

    // Abort, rescan and see the new colour
    resetn = 1'b0; tick(); resetn = 1'b1; tick();
    check("abort_busy", bus.scan_busy, 0);
    bus.scan_start = 1'b1; tick(); bus.scan_start = 1'b0;
    scan_pixels("rescan", 2, 1'b0, -1);
    check("rescan_new_colour", cap[0], 3'b011);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
